// File: rtl/lcd_text_sequencer_pkg.sv
// Shared definitions for the LCD text sequencer: FSM state encoding,
// HD44780-style command constants and screen geometry.
package lcd_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_ADDR = 3'd2,
        S_WAIT = 3'd3,
        S_DATA = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;
    localparam logic [7:0] LCD_LINE1_OFFSET  = 8'h40;
    localparam logic [7:0] LCD_BLANK         = 8'h20;

    localparam int LCD_CHARS_PER_LINE = 16;
    localparam int LCD_NUM_LINES      = 2;

    // Unprogrammed BRAM bytes read as zero; show them as spaces.
    function automatic logic [7:0] blank_fill(input logic [7:0] raw);
        logic [7:0] result;
        if (raw == 8'h00) begin
            result = LCD_BLANK;
        end else begin
            result = raw;
        end
        return result;
    endfunction

endpackage

// File: rtl/lcd_text_sequencer_if.sv
// BRAM read port plus LCD byte-writer valid/ready channel used by the sequencer.
interface lcd_text_sequencer_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              lcd_valid;
    logic              lcd_rs;
    logic [DATA_W-1:0] lcd_data;
    logic              lcd_ready;

    modport master (
        output mem_addr,
        output lcd_valid,
        output lcd_rs,
        output lcd_data,
        input  mem_data,
        input  lcd_ready
    );

    modport slave (
        input  mem_addr,
        input  lcd_valid,
        input  lcd_rs,
        input  lcd_data,
        output mem_data,
        output lcd_ready
    );
endinterface

// File: rtl/lcd_text_sequencer.sv
// Streams one 2x16 screen from character BRAM to the LCD byte writer:
// a Set-DDRAM-Address command per line followed by 16 character bytes.
module lcd_text_sequencer
    import lcd_pkg::*;
#(
    parameter int               ADDR_W         = 11,
    parameter int               DATA_W         = 8,
    parameter int               CHARS_PER_LINE = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR     = 11'h000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           page,
    lcd_text_sequencer_if.master bus,
    output logic                 busy,
    output logic                 done
);

    localparam int COL_W = $clog2(CHARS_PER_LINE);

    state_t              state_r, state_s;
    logic [1:0]          page_r, page_s;
    logic                line_r, line_s;
    logic [COL_W-1:0]    col_r, col_s;
    logic [ADDR_W-1:0]   mem_addr_r, mem_addr_s;
    logic                lcd_valid_r, lcd_valid_s;
    logic                lcd_rs_r, lcd_rs_s;
    logic [DATA_W-1:0]   lcd_data_r, lcd_data_s;
    logic                busy_r, busy_s;
    logic                done_r, done_s;
    logic                xfer_s;
    logic                last_col_s;

    // Address arithmetic wraps at ADDR_W bits by construction.
    function automatic logic [ADDR_W-1:0] char_addr(input logic [1:0] pg,
                                                    input logic ln,
                                                    input logic [COL_W-1:0] cl);
        return BASE_ADDR + ADDR_W'({pg, ln, cl});
    endfunction

    assign xfer_s     = lcd_valid_r & bus.lcd_ready;
    assign last_col_s = (col_r == COL_W'(CHARS_PER_LINE - 1));

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_s     = state_r;
        page_s      = page_r;
        line_s      = line_r;
        col_s       = col_r;
        mem_addr_s  = mem_addr_r;
        lcd_valid_s = lcd_valid_r;
        lcd_rs_s    = lcd_rs_r;
        lcd_data_s  = lcd_data_r;
        busy_s      = busy_r;
        done_s      = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (start) begin
                    page_s      = page;
                    line_s      = 1'b0;
                    state_s     = S_CMD;
                    lcd_valid_s = 1'b1;
                    lcd_rs_s    = 1'b0;
                    lcd_data_s  = DATA_W'(LCD_CMD_SET_DDRAM);
                    busy_s      = 1'b1;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_CMD: begin
                if (xfer_s) begin
                    col_s       = {COL_W{1'b0}};
                    mem_addr_s  = char_addr(page_r, line_r, {COL_W{1'b0}});
                    lcd_valid_s = 1'b0;
                    state_s     = S_ADDR;
                end else begin
                    state_s = S_CMD;
                end
            end
            S_ADDR: begin
                state_s = S_WAIT;
            end
            S_WAIT: begin
                lcd_data_s  = DATA_W'(blank_fill(8'(bus.mem_data)));
                lcd_rs_s    = 1'b1;
                lcd_valid_s = 1'b1;
                state_s     = S_DATA;
            end
            S_DATA: begin
                if (xfer_s && !last_col_s) begin
                    col_s       = col_r + COL_W'(1);
                    mem_addr_s  = char_addr(page_r, line_r, col_r + COL_W'(1));
                    lcd_valid_s = 1'b0;
                    state_s     = S_ADDR;
                end else if (xfer_s && !line_r) begin
                    line_s      = 1'b1;
                    lcd_valid_s = 1'b1;
                    lcd_rs_s    = 1'b0;
                    lcd_data_s  = DATA_W'(LCD_CMD_SET_DDRAM | LCD_LINE1_OFFSET);
                    state_s     = S_CMD;
                end else if (xfer_s) begin
                    lcd_valid_s = 1'b0;
                    done_s      = 1'b1;
                    state_s     = S_DONE;
                end else begin
                    state_s = S_DATA;
                end
            end
            S_DONE: begin
                busy_s  = 1'b0;
                state_s = S_IDLE;
            end
            default: begin
                state_s     = S_IDLE;
                lcd_valid_s = 1'b0;
                busy_s      = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= S_IDLE;
            page_r      <= 2'b00;
            line_r      <= 1'b0;
            col_r       <= {COL_W{1'b0}};
            mem_addr_r  <= {ADDR_W{1'b0}};
            lcd_valid_r <= 1'b0;
            lcd_rs_r    <= 1'b0;
            lcd_data_r  <= {DATA_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            page_r      <= page_s;
            line_r      <= line_s;
            col_r       <= col_s;
            mem_addr_r  <= mem_addr_s;
            lcd_valid_r <= lcd_valid_s;
            lcd_rs_r    <= lcd_rs_s;
            lcd_data_r  <= lcd_data_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    assign bus.mem_addr  = mem_addr_r;
    assign bus.lcd_valid = lcd_valid_r;
    assign bus.lcd_rs    = lcd_rs_r;
    assign bus.lcd_data  = lcd_data_r;
    assign busy          = busy_r;
    assign done          = done_r;

endmodule

// File: tb/tb_lcd_text_sequencer.sv
// Directed bench for lcd_text_sequencer: two instances (page-0 base and a zeroed
// base region) sharing stimulus, each backed by a 1-cycle-latency BRAM model.
module tb_lcd_text_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  page = 2'b00;
    logic        lcd_ready = 1'b1;
    logic        busy0, done0, busy1, done1;
    bit          sel = 1'b0;

    logic [7:0]  mem [0:2047];

    int checks = 0;
    int failures = 0;

    logic        cap_rs   [0:63];
    logic [7:0]  cap_data [0:63];
    logic [10:0] cap_addr [0:63];
    int          cap_n;

    always #5 clk = ~clk;

    lcd_text_sequencer_if #(.ADDR_W(11), .DATA_W(8)) if0 ();
    lcd_text_sequencer_if #(.ADDR_W(11), .DATA_W(8)) if1 ();

    assign if0.lcd_ready = lcd_ready;
    assign if1.lcd_ready = lcd_ready;

    always @(posedge clk) begin
        if0.mem_data <= mem[if0.mem_addr];
        if1.mem_data <= mem[if1.mem_addr];
    end

    lcd_text_sequencer #(.BASE_ADDR(11'h000)) dut0 (
        .clk(clk), .reset(reset), .start(start), .page(page),
        .bus(if0), .busy(busy0), .done(done0)
    );

    lcd_text_sequencer #(.BASE_ADDR(11'h080)) dut1 (
        .clk(clk), .reset(reset), .start(start), .page(page),
        .bus(if1), .busy(busy1), .done(done1)
    );

    wire        obs_valid = sel ? if1.lcd_valid : if0.lcd_valid;
    wire        obs_rs    = sel ? if1.lcd_rs    : if0.lcd_rs;
    wire [7:0]  obs_data  = sel ? if1.lcd_data  : if0.lcd_data;
    wire [10:0] obs_addr  = sel ? if1.mem_addr  : if0.mem_addr;
    wire        obs_busy  = sel ? busy1 : busy0;
    wire        obs_done  = sel ? done1 : done0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one screen; inputs for cycle n are set at the negedge inside cycle n.
    task automatic run_screen(input logic [1:0] pg, input int stall_at,
                              input int restart_at, input int exp_done);
        int n;
        int done_cyc;
        int busy_bad;
        int done_bad;
        int stall_bad;
        int nrs0;
        cap_n     = 0;
        done_cyc  = -1;
        busy_bad  = 0;
        done_bad  = 0;
        stall_bad = 0;
        nrs0      = 0;
        @(negedge clk);
        page  = pg;
        start = 1'b1;
        for (n = 1; n <= exp_done + 2; n++) begin
            @(negedge clk);
            start     = (n == restart_at);
            if (n == restart_at) page = 2'd2;
            lcd_ready = !(stall_at > 0 && n >= stall_at && n < stall_at + 5);
            if (obs_busy !== (n <= exp_done)) busy_bad++;
            if (obs_done !== (n == exp_done)) done_bad++;
            if (obs_done === 1'b1) done_cyc = n;
            if (stall_at > 0 && n >= stall_at && n <= stall_at + 5) begin
                if (!(obs_valid === 1'b1 && obs_data === 8'h48)) stall_bad++;
            end
            if (obs_valid === 1'b1 && lcd_ready === 1'b1 && cap_n < 64) begin
                cap_rs[cap_n]   = obs_rs;
                cap_data[cap_n] = obs_data;
                cap_addr[cap_n] = obs_addr;
                if (obs_rs === 1'b0) nrs0++;
                cap_n++;
            end
        end
        lcd_ready = 1'b1;
        page      = 2'b00;
        check("done_cycle", done_cyc, exp_done);
        check("done_pulse", done_bad, 0);
        check("busy_window", busy_bad, 0);
        check("byte_count", cap_n, 34);
        check("cmd_count", nrs0, 2);
        if (stall_at > 0) check("stall_hold", stall_bad, 0);
    endtask

    // Compares the captured stream against the BRAM image.
    task automatic check_stream(input logic [10:0] base, input logic [1:0] pg);
        logic [10:0] a;
        logic [7:0]  d;
        int          ln;
        int          cl;
        for (int i = 0; i < 34; i++) begin
            if (i == 0 || i == 17) begin
                check("cmd_byte", {cap_rs[i], cap_data[i]}, {1'b0, (i == 0) ? 8'h80 : 8'hC0});
            end else begin
                ln = (i > 17) ? 1 : 0;
                cl = i - 1 - 17 * ln;
                a  = base + 11'(pg * 32 + ln * 16 + cl);
                d  = (mem[a] == 8'h00) ? 8'h20 : mem[a];
                check("char_byte", {cap_rs[i], cap_data[i], cap_addr[i]}, {1'b1, d, a});
            end
        end
    endtask

    initial begin
        int vbad;
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        for (int i = 0; i < 128; i++) mem[i] = 8'h30 + 8'(i % 32);
        for (int i = 0; i < 16; i++) mem[i] = 8'h41 + 8'(i);
        for (int i = 0; i < 15; i++) mem[16 + i] = 8'h61 + 8'(i);
        mem[31]  = 8'h5E;
        mem[63]  = 8'h3E;
        mem[127] = 8'h3C;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_addr", if0.mem_addr, 11'h000);
        check("rst_valid", if0.lcd_valid, 1'b0);
        check("rst_rs", if0.lcd_rs, 1'b0);
        check("rst_data", if0.lcd_data, 8'h00);
        check("rst_busy", busy0, 1'b0);
        check("rst_done", done0, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Page 0, standard image
        sel = 1'b0;
        run_screen(2'd0, 0, 0, 99);
        check_stream(11'h000, 2'd0);
        check("p0_first", cap_data[0], 8'h80);
        check("p0_c0", cap_data[1], 8'h41);
        check("p0_c15", cap_data[16], 8'h50);
        check("p0_cmd1", cap_data[17], 8'hC0);
        check("p0_l1c0", cap_data[18], 8'h61);
        check("p0_l1c14", cap_data[32], 8'h6F);
        check("p0_last", cap_data[33], 8'h5E);

        // Page 1
        run_screen(2'd1, 0, 0, 99);
        check_stream(11'h000, 2'd1);
        check("p1_addr_first", cap_addr[1], 11'h020);
        check("p1_addr_last", cap_addr[33], 11'h03F);
        check("p1_last", cap_data[33], 8'h3E);

        // Page 3
        run_screen(2'd3, 0, 0, 99);
        check_stream(11'h000, 2'd3);
        check("p3_last", cap_data[33], 8'h3C);
        check("p3_addr_last", cap_addr[33], 11'h07F);

        // Zeroed base region on the second instance
        sel = 1'b1;
        run_screen(2'd0, 0, 0, 99);
        check_stream(11'h080, 2'd0);
        check("zb_addr_first", cap_addr[1], 11'h080);
        check("zb_c0", cap_data[1], 8'h20);
        check("zb_last", cap_data[33], 8'h20);
        check("zb_cmd0", cap_data[0], 8'h80);
        check("zb_cmd1", cap_data[17], 8'hC0);
        sel = 1'b0;

        // Five-cycle stall on character 7 of line 0
        run_screen(2'd0, 25, 0, 104);
        check_stream(11'h000, 2'd0);
        check("stall_c7", cap_data[8], 8'h48);

        // Second start mid-screen with page 2 is ignored
        run_screen(2'd0, 0, 40, 99);
        check_stream(11'h000, 2'd0);
        check("restart_addr_last", cap_addr[33], 11'h01F);

        // Asynchronous reset in cycle 30
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        check("pre_abort_busy", busy0, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("abort_addr", if0.mem_addr, 11'h000);
        check("abort_valid", if0.lcd_valid, 1'b0);
        check("abort_rs", if0.lcd_rs, 1'b0);
        check("abort_data", if0.lcd_data, 8'h00);
        check("abort_busy", busy0, 1'b0);
        check("abort_done", done0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        vbad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (if0.lcd_valid !== 1'b0 || busy0 !== 1'b0) vbad++;
        end
        check("post_abort_idle", vbad, 0);
        run_screen(2'd0, 0, 0, 99);
        check_stream(11'h000, 2'd0);
        check("post_abort_first", cap_data[0], 8'h80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
